// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and the writeback entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] val;
  } wb_entry_t;
endpackage

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: synchronous FIFO of wb_entry_t; pointers carry an extra MSB to tell full from empty
module riscv_wb_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  always_comb begin
    wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d = pop ? rptr_q + (AW+1)'(1) : rptr_q;
    empty = wptr_q == rptr_q;
    full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    dout = mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) mem_q[wptr_q[AW-1:0]] <= din;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/riscv_wb_stage.sv
// riscv_wb_stage: ALU/LSU writeback arbiter with LSU buffer FIFO and busy-register scoreboard
// Optional bypass ports enabled by RISCV_WB_BYPASS_EN
module riscv_wb_stage import riscv_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_val,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_val,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [31:0]           busy_mask,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] dreg_num,
  output logic [XLEN-1:0]       dreg_val
`ifdef RISCV_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] byp_rd,
  output logic                  byp_hit,
  output logic [XLEN-1:0]       byp_val
`endif
);
  wb_entry_t head, sel_e;
  logic full, empty, accept, sel_fifo, sel_fast, push;
  logic we_q;
  logic [REG_ADDR_W-1:0] dreg_num_q;
  logic [XLEN-1:0] dreg_val_q;
  logic [31:0] busy_q, busy_d;
  riscv_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(wb_entry_t'{rd: lsu_rd, val: lsu_val}),
    .pop(sel_fifo),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // priority: ALU, then buffered LSU, then LSU fast path only when nothing is buffered
  always_comb begin
    lsu_ready = !full && !rst;
    accept = lsu_valid && lsu_ready;
    sel_fifo = !alu_valid && !empty;
    sel_fast = !alu_valid && empty && accept;
    push = accept && !sel_fast;
    sel_e = alu_valid ? wb_entry_t'{rd: alu_rd, val: alu_val} :
            sel_fifo ? head : wb_entry_t'{rd: lsu_rd, val: lsu_val};
    busy_d = busy_q;
    if (sel_fifo || sel_fast) busy_d[sel_e.rd] = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      dreg_num_q <= '0;
      dreg_val_q <= '0;
      busy_q <= '0;
    end else begin
      we_q <= (alu_valid || sel_fifo || sel_fast) && sel_e.rd != '0;
      if (alu_valid || sel_fifo || sel_fast) begin
        dreg_num_q <= sel_e.rd;
        dreg_val_q <= sel_e.val;
      end
      busy_q <= busy_d;
    end
  end
  assign we = we_q;
  assign dreg_num = dreg_num_q;
  assign dreg_val = dreg_val_q;
  assign busy_mask = busy_q;
`ifdef RISCV_WB_BYPASS_EN
  assign byp_hit = we_q && byp_rd != '0 && byp_rd == dreg_num_q;
  assign byp_val = dreg_val_q;
`endif
endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb_riscv_wb_stage: directed vectors with hand-computed expectations for riscv_wb_stage
module tb_riscv_wb_stage;
  logic clk = 1'b0;
  logic rst, alu_valid, lsu_valid, lsu_ready, issue_valid, we;
  logic [4:0] alu_rd, lsu_rd, issue_rd, dreg_num;
  logic [31:0] alu_val, lsu_val, busy_mask, dreg_val;
`ifdef RISCV_WB_BYPASS_EN
  logic [4:0] byp_rd;
  logic byp_hit;
  logic [31:0] byp_val;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  riscv_wb_stage #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_val(lsu_val),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
    .we(we), .dreg_num(dreg_num), .dreg_val(dreg_val)
`ifdef RISCV_WB_BYPASS_EN
    , .byp_rd(byp_rd), .byp_hit(byp_hit), .byp_val(byp_val)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
  endtask
  task automatic alu(input logic [4:0] rd, input logic [31:0] v);
    alu_valid = 1; alu_rd = rd; alu_val = v;
  endtask
  task automatic lsu(input logic [4:0] rd, input logic [31:0] v);
    lsu_valid = 1; lsu_rd = rd; lsu_val = v;
  endtask
  task automatic wb(input string tag, input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_val);
    chk({tag, ".we"}, 32'(we), 32'(e_we));
    if (e_we) begin
      chk({tag, ".rd"}, 32'(dreg_num), 32'(e_rd));
      chk({tag, ".val"}, dreg_val, e_val);
    end
  endtask
  initial begin
    rst = 1; idle(); alu_rd = 0; alu_val = 0; lsu_rd = 0; lsu_val = 0; issue_rd = 0;
`ifdef RISCV_WB_BYPASS_EN
    byp_rd = 0;
`endif
    step(); step();
    chk("rst.we", 32'(we), 0);
    chk("rst.rd", 32'(dreg_num), 0);
    chk("rst.val", dreg_val, 0);
    chk("rst.busy", busy_mask, 0);
    chk("rst.ready", 32'(lsu_ready), 0);
    rst = 0; #1;
    chk("ready_after_rst", 32'(lsu_ready), 1);
    alu(5, 32'h1234); step(); idle();
    wb("alu", 1, 5, 32'h1234);
    step();
    chk("alu_idle.we", 32'(we), 0);
    chk("alu_idle.hold_rd", 32'(dreg_num), 5);
    chk("alu_idle.hold_val", dreg_val, 32'h1234);
    alu(1, 32'hA); lsu(2, 32'hB); step(); idle();
    wb("conf1", 1, 1, 32'hA);
    step();
    wb("conf2", 1, 2, 32'hB);
    step();
    chk("conf_idle.we", 32'(we), 0);
    for (int i = 0; i < 4; i++) begin
      alu(3, 32'h100 + i); lsu(5'(10 + i), 32'h200 + i); step();
      wb("fill_alu", 1, 3, 32'h100 + i);
      chk("fill_ready", 32'(lsu_ready), (i < 3) ? 1 : 0);
    end
    alu(3, 32'h1FF); lsu(14, 32'h2FF); step();
    chk("fill_held_ready", 32'(lsu_ready), 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      wb("drain", 1, 5'(10 + i), 32'h200 + i);
    end
    step();
    chk("drain_done.we", 32'(we), 0);
    chk("drain_done.ready", 32'(lsu_ready), 1);
    chk("drain_busy", busy_mask, 0);
    issue_valid = 1; issue_rd = 7; step(); idle();
    chk("sb_set", busy_mask, 32'h80);
    step(); step(); step();
    chk("sb_hold", busy_mask, 32'h80);
    lsu(7, 32'h77); step(); idle();
    wb("sb_clr_wb", 1, 7, 32'h77);
    chk("sb_clr", busy_mask, 0);
    issue_valid = 1; issue_rd = 7; step();
    lsu(7, 32'h78); step(); idle();
    wb("sb_same_wb", 1, 7, 32'h78);
    chk("sb_set_wins", busy_mask, 32'h80);
    lsu(7, 32'h79); step(); idle();
    chk("sb_clr2", busy_mask, 0);
    issue_valid = 1; issue_rd = 0; step(); idle();
    chk("sb_x0", busy_mask, 0);
    issue_valid = 1; issue_rd = 8; step();
    idle(); alu(8, 32'h88); step(); idle();
    wb("sb_alu_wb", 1, 8, 32'h88);
    chk("sb_alu_keep", busy_mask, 32'h100);
    lsu(8, 32'h89); step(); idle();
    chk("sb_lsu_clr", busy_mask, 0);
    lsu(0, 32'h99); step(); idle();
    chk("x0.we", 32'(we), 0);
    chk("x0.busy", busy_mask, 0);
    step();
    chk("x0.consumed", 32'(we), 0);
    issue_valid = 1; issue_rd = 20;
    for (int i = 0; i < 3; i++) begin
      alu(3, 32'h300 + i); lsu(5'(20 + i), 32'h400 + i); step();
      issue_valid = 0;
    end
    chk("pre_rst.busy", busy_mask, 32'h0010_0000);
    idle(); rst = 1; step();
    wb("mid_rst", 0, 0, 0);
    chk("mid_rst.rd", 32'(dreg_num), 0);
    chk("mid_rst.busy", busy_mask, 0);
    rst = 0; #1;
    chk("mid_rst.ready", 32'(lsu_ready), 1);
    step();
    chk("post_rst.we", 32'(we), 0);
    step();
    chk("post_rst2.we", 32'(we), 0);
`ifdef RISCV_WB_BYPASS_EN
    alu(9, 32'h55); step(); idle();
    byp_rd = 9; #1;
    chk("byp.hit", 32'(byp_hit), 1);
    chk("byp.val", byp_val, 32'h55);
    byp_rd = 0; #1;
    chk("byp.x0", 32'(byp_hit), 0);
    byp_rd = 4; #1;
    chk("byp.miss", 32'(byp_hit), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
